// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
// These are default parameter values and common RISC-V encodings.
package if_prefetch_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned DEPTH_DEF   = 4;
   localparam logic [31:0] RST_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO that holds {pc, instruction} pairs in fetch order.
// clr has priority over push and pop. A push and a pop in the same cycle are legal when full.
module if_prefetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   input  logic                       clr_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: state registers use non-blocking assignments, so every block samples values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is not reset. The count marks it invalid, and a reset would only add cost.
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage. It issues SRAM word requests under a credit limit and queues the returned instructions with their PCs.
// A redirect flushes the queue and discards the responses still in flight.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int unsigned     XLEN    = XLEN_DEF,
   parameter int unsigned     ADDR_W  = ADDR_W_DEF,
   parameter int unsigned     DEPTH   = DEPTH_DEF,
   parameter logic [XLEN-1:0] RST_VEC = XLEN'(RST_VEC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              brh,
   input  logic [XLEN-1:0]   brh_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [XLEN-1:0]   inst_data,
   output logic [XLEN-1:0]   inst_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, brh_tgt;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, fifo_count;
   logic [CNT_W:0]    in_flight;
   logic [2*XLEN-1:0] fifo_head;
   logic              issue, resp, dropping, push, pop, fifo_full, fifo_empty;

   assign brh_tgt   = brh_addr & ~XLEN'(3);
   assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};

   // Requests are throttled so that every response in flight has a guaranteed queue slot.
   assign mem_req  = !rst && !brh && (in_flight < (CNT_W+1)'(DEPTH));
   assign mem_addr = fetch_pc_q[ADDR_W+1:2];
   assign issue    = mem_req && mem_gnt;
   assign resp     = mem_rvalid && (outstanding_q != '0);
   assign dropping = resp && (drop_cnt_q != '0);
   assign push     = resp && !dropping && !brh;
   assign pop      = inst_valid && inst_ready && !brh;

   assign inst_valid = !fifo_empty;
   assign inst_data  = inst_valid ? fifo_head[XLEN-1:0]      : '0;
   assign inst_pc    = inst_valid ? fifo_head[2*XLEN-1:XLEN] : '0;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp);
      if (brh) begin
         fetch_pc_d = brh_tgt;
         resp_pc_d  = brh_tgt;
         drop_cnt_d = outstanding_q - CNT_W'(resp);
      end else begin
         if (issue)    fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (push)     resp_pc_d  = resp_pc_q + XLEN'(4);
         if (dropping) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RST_VEC;
         resp_pc_q     <= RST_VEC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   if_prefetch_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({resp_pc_q, mem_rdata}),
      .pop_i   (pop),
      .clr_i   (brh),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   a_rvalid_legal: assert property (@(posedge clk) disable iff (rst)
      mem_rvalid |-> (outstanding_q != '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (fifo_full && push) |-> pop);

endmodule

// File: tb/tb_if_prefetch.sv
// Randomised bench for if_prefetch. An in-order SRAM model with variable latency drives the DUT.
// A stream-level reference model supplies the expected requests and instruction order.
module tb_if_prefetch;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_VEC = 32'h0;

   logic              clk, rst, brh, mem_gnt, mem_rvalid, inst_ready;
   logic [XLEN-1:0]   brh_addr, mem_rdata, inst_data, inst_pc;
   logic              mem_req, inst_valid;
   logic [ADDR_W-1:0] mem_addr;

   if_prefetch #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_VEC(RST_VEC)) dut (
      .clk        (clk),
      .rst        (rst),
      .brh        (brh),
      .brh_addr   (brh_addr),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] maddr;
      logic [31:0]       pc;
      int unsigned       epoch;
      int unsigned       due;
   } req_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_t;

   req_t        pend[$];
   inst_t       expq[$];
   logic [31:0] model_pc;
   int unsigned epoch, cyc, lat;
   int          checks, errors, issues, pops;

   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      return {a, ~a} ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Runs one clock cycle. It is entered and left just after a falling edge.
   task automatic step(input bit b, input logic [31:0] baddr, input bit g, input bit r);
      bit    rv, exp_req, issue;
      req_t  h;
      inst_t e;
      rv = (pend.size() > 0) && (pend[0].due <= cyc);
      brh        = b;
      brh_addr   = baddr;
      mem_gnt    = g;
      inst_ready = r;
      mem_rvalid = rv;
      mem_rdata  = rv ? mem_word(pend[0].maddr) : '0;
      #1;
      exp_req = !b && ((pend.size() + expq.size()) < DEPTH);
      check("mem_req", mem_req, exp_req);
      if (exp_req) check("mem_addr", mem_addr, model_pc[ADDR_W+1:2]);
      check("inst_valid", inst_valid, expq.size() != 0);
      if (expq.size() != 0) begin
         check("inst_pc", inst_pc, expq[0].pc);
         check("inst_data", inst_data, expq[0].data);
      end else begin
         check("inst_pc_idle", inst_pc, 0);
         check("inst_data_idle", inst_data, 0);
      end
      issue = exp_req && g;
      @(posedge clk);
      if (!b && r && expq.size() != 0) begin
         void'(expq.pop_front());
         pops++;
      end
      if (rv) begin
         h = pend.pop_front();
         if (!b && h.epoch == epoch) begin
            e.pc   = h.pc;
            e.data = mem_word(h.pc[ADDR_W+1:2]);
            expq.push_back(e);
         end
      end
      if (b) begin
         expq.delete();
         epoch++;
         model_pc = baddr & ~32'h3;
      end else if (issue) begin
         h.maddr = mem_addr;
         h.pc    = model_pc;
         h.epoch = epoch;
         h.due   = cyc + lat;
         pend.push_back(h);
         model_pc = model_pc + 32'd4;
         issues++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic model_reset();
      pend.delete();
      expq.delete();
      model_pc = RST_VEC;
      epoch++;
   endtask

   task automatic idle_inputs();
      brh = 0; brh_addr = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; inst_ready = 0;
   endtask

   initial begin
      checks = 0; errors = 0; issues = 0; pops = 0; cyc = 0; epoch = 0; lat = 1;
      idle_inputs();
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_inst_data", inst_data, 0);
      @(negedge clk);
      rst = 0;

      // Decode stalled: only DEPTH requests may be issued before the credit runs out.
      issues = 0;
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
      check("stall_issue_count", issues, DEPTH);

      // Full-rate streaming: one pop per cycle once steady.
      for (int i = 0; i < 10; i++) step(0, '0, 1, 1);
      pops = 0;
      for (int i = 0; i < 10; i++) step(0, '0, 1, 1);
      check("steady_pop_rate", pops, 10);

      // Redirect that coincides with a response and a pop.
      step(1, 32'h0000_0040, 1, 1);
      for (int i = 0; i < 8; i++) step(0, '0, 1, 1);

      // Latency 3 with redirect while responses are outstanding.
      lat = 3;
      for (int i = 0; i < 6; i++) step(0, '0, 1, 1);
      step(1, 32'h0000_0100, 1, 1);
      for (int i = 0; i < 12; i++) step(0, '0, 1, 1);

      // Unaligned target at the top of the address space wraps to 0.
      step(1, 32'hFFFF_FFFE, 1, 1);
      for (int i = 0; i < 12; i++) step(0, '0, 1, 1);

      // Back-to-back redirects: the last target wins.
      step(1, 32'h0000_2000, 1, 1);
      step(1, 32'h0000_3004, 1, 1);
      for (int i = 0; i < 12; i++) step(0, '0, 1, 1);

      // Reset asserted between edges mid-burst.
      #2;
      rst = 1;
      #1;
      check("midrst_mem_req", mem_req, 0);
      check("midrst_inst_valid", inst_valid, 0);
      check("midrst_inst_pc", inst_pc, 0);
      idle_inputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      lat = 1;
      for (int i = 0; i < 8; i++) step(0, '0, 1, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         bit          b;
         if ($urandom_range(0, 99) == 0) lat = $urandom_range(1, 3);
         b   = ($urandom_range(0, 99) < 4);
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
         step(b, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
